// File: rtl/cpu_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_debug_ctrl
//  Description : CPU run-control (halt / single-step / prescaled free-run /
//                PC breakpoint) generating a one-cycle cpu_ce, plus an
//                executed-cycle counter and a registered, freezable display mux.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_debug_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NCH     = 4,
   parameter int SEL_W   = 2,
   parameter int CNT_W   = 16,
   parameter int RUN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  step_btn_i,
   input  logic                  run_btn_i,
   input  logic                  bp_en_i,
   input  logic [ADDR_W-1:0]     bp_addr_i,
   input  logic [ADDR_W-1:0]     pc_i,
   input  logic [NCH*DATA_W-1:0] ch_data_i,
   input  logic [SEL_W-1:0]      ch_sel_i,
   input  logic                  freeze_i,
   output logic                  cpu_ce_o,
   output logic [CNT_W-1:0]      cyc_cnt_o,
   output logic [1:0]            run_state_o,
   output logic                  bp_hit_o,
   output logic [DATA_W-1:0]     disp_data_o
);

   localparam int PRESC_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
   localparam logic [PRESC_W-1:0] C_PRESC_MAX = PRESC_W'(RUN_DIV - 1);
   localparam logic [PRESC_W-1:0] C_PRESC_ONE = PRESC_W'(1);
   localparam logic [CNT_W-1:0]   C_CNT_ZERO  = '0;

   typedef enum logic [1:0] {
      ST_HALT  = 2'b00,
      ST_STEP  = 2'b01,
      ST_RUN   = 2'b10,
      ST_BREAK = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic                step_q, run_q;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic                bp_skip_q, bp_skip_d;
   logic                cpu_ce_q, cpu_ce_d;
   logic [CNT_W-1:0]    cyc_cnt_q;
   logic [DATA_W-1:0]   disp_q, disp_d;
   logic [DATA_W-1:0]   disp_sel;

   logic step_rise, run_rise, bp_match;

   assign step_rise = step_btn_i & ~step_q;
   assign run_rise  = run_btn_i  & ~run_q;
   assign bp_match  = bp_en_i && (pc_i == bp_addr_i);

   // Run-control registers; button history resets high so a held button is not an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_HALT;
         step_q    <= 1'b1;
         run_q     <= 1'b1;
         presc_q   <= '0;
         bp_skip_q <= 1'b0;
         cpu_ce_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_btn_i;
         run_q     <= run_btn_i;
         presc_q   <= presc_d;
         bp_skip_q <= bp_skip_d;
         cpu_ce_q  <= cpu_ce_d;
      end
   end

   // Next-state logic; cpu_ce_d is raised on the edge that enters STEP or issues a RUN tick
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      bp_skip_d = bp_skip_q;
      cpu_ce_d  = 1'b0;
      case (state_q)
         ST_HALT: begin
            if (run_rise) begin
               state_d = ST_RUN;
               presc_d = '0;
            end else if (step_rise) begin
               state_d  = ST_STEP;
               cpu_ce_d = 1'b1;
            end
         end
         ST_STEP: begin
            state_d = ST_HALT;
         end
         ST_RUN: begin
            if (run_rise) begin
               state_d = ST_HALT;
            end else if (presc_q == C_PRESC_MAX) begin
               presc_d = '0;
               if (bp_match && !bp_skip_q) begin
                  state_d = ST_BREAK;
               end else begin
                  cpu_ce_d  = 1'b1;
                  bp_skip_d = 1'b0;
               end
            end else begin
               presc_d = presc_q + C_PRESC_ONE;
            end
         end
         ST_BREAK: begin
            // Resuming sets bp_skip so the instruction sitting on the breakpoint runs once
            if (run_rise) begin
               state_d   = ST_RUN;
               presc_d   = '0;
               bp_skip_d = 1'b1;
            end else if (step_rise) begin
               state_d  = ST_STEP;
               cpu_ce_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   // Executed-cycle counter, one cycle behind each cpu_ce pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt_q <= '0;
      end else begin
         cyc_cnt_q <= cyc_cnt_q + {C_CNT_ZERO[CNT_W-1:1], cpu_ce_q};
      end
   end

   // Channel select; out-of-range selects read as zero
   always_comb begin
      disp_sel = '0;
      for (int k = 0; k < NCH; k++) begin
         if (ch_sel_i == SEL_W'(k)) begin
            disp_sel = ch_data_i[k*DATA_W +: DATA_W];
         end
      end
      disp_d = freeze_i ? disp_q : disp_sel;
   end

   // Display register
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_q <= '0;
      end else begin
         disp_q <= disp_d;
      end
   end

   assign cpu_ce_o    = cpu_ce_q;
   assign cyc_cnt_o   = cyc_cnt_q;
   assign run_state_o = state_q;
   assign bp_hit_o    = (state_q == ST_BREAK);
   assign disp_data_o = disp_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_debug_ctrl
//  Description : Self-checking bench for cpu_debug_ctrl. Expected cpu_ce
//                cycles and display words are queued when stimulus is driven
//                and popped when the DUT produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_debug_ctrl;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int NCH     = 3;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 4;
   localparam int RUN_DIV = 4;

   localparam logic [DATA_W-1:0] C_CH_A = 32'hAAAA_0001;
   localparam logic [DATA_W-1:0] C_CH_B = 32'hBBBB_0002;
   localparam logic [DATA_W-1:0] C_CH_C = 32'hCCCC_0003;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  step_btn, run_btn, bp_en, freeze;
   logic [ADDR_W-1:0]     bp_addr, pc;
   logic [NCH*DATA_W-1:0] ch_data;
   logic [SEL_W-1:0]      ch_sel;
   logic                  cpu_ce;
   logic [CNT_W-1:0]      cyc_cnt;
   logic [1:0]            run_state;
   logic                  bp_hit;
   logic [DATA_W-1:0]     disp_data;

   cpu_debug_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCH(NCH), .SEL_W(SEL_W),
      .CNT_W(CNT_W), .RUN_DIV(RUN_DIV)
   ) dut (
      .clk(clk), .rst(rst),
      .step_btn_i(step_btn), .run_btn_i(run_btn),
      .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
      .ch_data_i(ch_data), .ch_sel_i(ch_sel), .freeze_i(freeze),
      .cpu_ce_o(cpu_ce), .cyc_cnt_o(cyc_cnt), .run_state_o(run_state),
      .bp_hit_o(bp_hit), .disp_data_o(disp_data)
   );

   always #5 clk = ~clk;

   // Cycle index: number of rising edges so far, stable at the falling edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Minimal CPU: pc advances by 4 on every cpu_ce
   always @(posedge clk) begin
      if (rst) pc <= '0;
      else if (cpu_ce) pc <= pc + 32'd4;
   end

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      int                due;
      logic [DATA_W-1:0] val;
   } disp_exp_t;

   int        ce_q[$];
   disp_exp_t disp_q[$];

   // cpu_ce scoreboard: every pulse must match the head of the queue
   always @(negedge clk) begin
      int exp_c;
      if (cpu_ce === 1'b1) begin
         exp_c = (ce_q.size() > 0) ? ce_q[0] : -1;
         check_eq("ce_cycle", cyc, exp_c);
         if (ce_q.size() > 0 && ce_q[0] == cyc) void'(ce_q.pop_front());
      end else if (ce_q.size() > 0 && ce_q[0] <= cyc) begin
         check_eq("ce_missing", {31'd0, cpu_ce}, 32'd1);
         void'(ce_q.pop_front());
      end
   end

   // Display scoreboard: compare at the cycle each entry falls due
   always @(negedge clk) begin
      if (disp_q.size() > 0 && disp_q[0].due <= cyc) begin
         check_eq("disp", disp_data, disp_q[0].val);
         void'(disp_q.pop_front());
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(1);
   endtask

   task automatic drive_disp(input logic [SEL_W-1:0] sel, input logic frz, input logic [DATA_W-1:0] exp);
      ch_sel = sel;
      freeze = frz;
      disp_q.push_back('{due: cyc + 1, val: exp});
      wait_cyc(1);
   endtask

   initial begin
      int n;
      rst      = 1'b1;
      step_btn = 1'b0;
      run_btn  = 1'b0;
      bp_en    = 1'b0;
      bp_addr  = '0;
      freeze   = 1'b0;
      ch_sel   = 2'd2;
      ch_data  = {C_CH_C, C_CH_B, C_CH_A};

      // Reset state
      wait_cyc(2);
      check_eq("rst_state", run_state, 2'b00);
      check_eq("rst_ce", cpu_ce, 1'b0);
      check_eq("rst_cnt", cyc_cnt, 4'd0);
      check_eq("rst_bphit", bp_hit, 1'b0);
      check_eq("rst_disp", disp_data, 32'd0);
      rst = 1'b0;
      wait_cyc(2);

      // Single step with button held 10 cycles
      step_btn = 1'b1;
      ce_q.push_back(cyc + 1);
      wait_cyc(1);
      check_eq("step_state", run_state, 2'b01);
      wait_cyc(9);
      step_btn = 1'b0;
      wait_cyc(1);
      check_eq("step_cnt", cyc_cnt, 4'd1);
      check_eq("step_halt", run_state, 2'b00);

      // Free run: ce every 4th clk, stop coincides with a pending tick
      n = cyc;
      run_btn = 1'b1;
      ce_q.push_back(n + 5); ce_q.push_back(n + 9); ce_q.push_back(n + 13);
      wait_cyc(1);
      run_btn = 1'b0;
      check_eq("run_state", run_state, 2'b10);
      wait_cyc(15);
      run_btn = 1'b1;
      wait_cyc(1);
      run_btn = 1'b0;
      check_eq("stop_state", run_state, 2'b00);
      wait_cyc(8);
      check_eq("run_cnt", cyc_cnt, 4'd4);
      check_eq("run_q_empty", ce_q.size(), 0);

      // Breakpoint at 0x0C
      do_reset();
      bp_en   = 1'b1;
      bp_addr = 32'h0000_000C;
      n = cyc;
      run_btn = 1'b1;
      ce_q.push_back(n + 5); ce_q.push_back(n + 9); ce_q.push_back(n + 13);
      wait_cyc(1);
      run_btn = 1'b0;
      wait_cyc(19);
      check_eq("bp_state", run_state, 2'b11);
      check_eq("bp_hit", bp_hit, 1'b1);
      check_eq("bp_cnt", cyc_cnt, 4'd3);
      check_eq("bp_pc", pc, 32'h0000_000C);
      wait_cyc(4);
      check_eq("bp_hold", run_state, 2'b11);

      // Resume: the instruction on the breakpoint executes, no re-break
      n = cyc;
      run_btn = 1'b1;
      ce_q.push_back(n + 5); ce_q.push_back(n + 9); ce_q.push_back(n + 13);
      wait_cyc(1);
      run_btn = 1'b0;
      check_eq("resume_state", run_state, 2'b10);
      check_eq("resume_bphit", bp_hit, 1'b0);
      wait_cyc(13);
      run_btn = 1'b1;
      wait_cyc(1);
      run_btn = 1'b0;
      check_eq("resume_stop", run_state, 2'b00);
      wait_cyc(4);
      check_eq("resume_cnt", cyc_cnt, 4'd6);
      check_eq("resume_pc", pc, 32'h0000_0018);

      // Step ignores a matching breakpoint
      bp_addr = 32'h0000_0018;
      step_btn = 1'b1;
      ce_q.push_back(cyc + 1);
      wait_cyc(1);
      step_btn = 1'b0;
      wait_cyc(3);
      check_eq("stepbp_cnt", cyc_cnt, 4'd7);
      check_eq("stepbp_state", run_state, 2'b00);

      // Coincident run and step rises: run wins
      step_btn = 1'b1;
      run_btn  = 1'b1;
      wait_cyc(1);
      check_eq("prio_state", run_state, 2'b10);
      step_btn = 1'b0;
      run_btn  = 1'b0;
      wait_cyc(1);
      run_btn = 1'b1;
      wait_cyc(1);
      run_btn = 1'b0;
      check_eq("prio_stop", run_state, 2'b00);
      wait_cyc(4);

      // Display mux, freeze and out-of-range select
      drive_disp(2'd2, 1'b0, C_CH_C);
      drive_disp(2'd0, 1'b1, C_CH_C);
      drive_disp(2'd1, 1'b1, C_CH_C);
      drive_disp(2'd3, 1'b0, 32'd0);
      drive_disp(2'd1, 1'b0, C_CH_B);
      drive_disp(2'd0, 1'b0, C_CH_A);
      wait_cyc(1);

      // Counter wrap after 16 steps
      bp_en = 1'b0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step_btn = 1'b1;
         ce_q.push_back(cyc + 1);
         wait_cyc(1);
         step_btn = 1'b0;
         wait_cyc(1);
         if (i == 14) check_eq("cnt_15", cyc_cnt, 4'd15);
      end
      check_eq("cnt_wrap", cyc_cnt, 4'd0);

      // Buttons rising together with reset and held through its release
      step_btn = 1'b1;
      run_btn  = 1'b1;
      rst      = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(6);
      check_eq("held_state", run_state, 2'b00);
      check_eq("held_cnt", cyc_cnt, 4'd0);
      step_btn = 1'b0;
      run_btn  = 1'b0;
      wait_cyc(2);

      // Reset just before a pending tick drops it
      run_btn = 1'b1;
      wait_cyc(1);
      run_btn = 1'b0;
      wait_cyc(3);
      rst = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(6);
      check_eq("midrst_state", run_state, 2'b00);
      check_eq("midrst_cnt", cyc_cnt, 4'd0);

      wait_cyc(2);
      check_eq("ce_q_empty", ce_q.size(), 0);
      check_eq("disp_q_empty", disp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
